// File: rtl/nand_lu_pkg.sv
// Shared definitions for the NAND logic unit: opcodes, fold FSM states
// and the per-beat bitwise function.
package nand_lu_pkg;

   localparam logic [2:0] OP_NAND = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_FOLD = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FOLD = 1'b1
   } fold_state_e;

   // Operands are carried at the widest legal width; callers truncate.
   // FOLD maps to a pass-through of a, which is the single-beat fold result.
   function automatic logic [31:0] logic_op(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] y;
      case (op)
         OP_NAND: y = ~(a & b);
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         default: y = a;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/nand_lu_stage.sv
// One elastic register slice: loads when empty or when its content leaves
// in the same cycle, otherwise holds valid and data stable.
module nand_lu_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             load;

   always_comb begin
      load    = in_valid_i & (~valid_q | out_ready_i);
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/nand_logic_unit.sv
// Pipelined bitwise logic unit with NAND fold bursts, elastic valid/ready
// stages and a wrapping count of delivered results.
module nand_logic_unit
   import nand_lu_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [CNT_W-1:0] out_count
);

   // Handshake: a beat moves on in_valid & in_ready, a result moves on
   // out_valid & out_ready; valid never waits on ready.

   fold_state_e      fold_state_q;
   logic [WIDTH-1:0] acc_q;
   logic             rdy_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] acc_nand;
   logic [WIDTH-1:0] op_res;
   logic             needs_push;
   logic [WIDTH-1:0] push_data;
   logic             push_valid;
   logic             in_xfer;

   logic [PIPE_STAGES-1:0] stg_v;
   logic [WIDTH-1:0]       stg_d [PIPE_STAGES];
   logic [PIPE_STAGES:0]   rdy_c;

   always_comb begin
      acc_nand   = ~(acc_q & in_a);
      op_res     = WIDTH'(logic_op(in_op, 32'(in_a), 32'(in_b)));
      needs_push = 1'b1;
      push_data  = op_res;
      if (fold_state_q == ST_FOLD) begin
         needs_push = in_last;
         push_data  = acc_nand;
      end else if (in_op == OP_FOLD) begin
         needs_push = in_last;
         push_data  = in_a;
      end
   end

   // Ready of each stage computed from the output side back to the input.
   always_comb begin
      rdy_c[PIPE_STAGES] = out_ready;
      for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
         rdy_c[i] = ~stg_v[i] | rdy_c[i+1];
      end
   end

   // Non-last fold beats only touch the accumulator, so they never stall.
   assign in_ready   = rdy_q & (~needs_push | rdy_c[0]);
   assign in_xfer    = in_valid & in_ready;
   assign push_valid = in_valid & rdy_q & needs_push;

   genvar g;
   generate
      for (g = 0; g < PIPE_STAGES; g++) begin : g_stage
         if (g == 0) begin : g_first
            nand_lu_stage #(.WIDTH(WIDTH)) u_stage (
               .clk         (clk),
               .rst         (rst),
               .in_valid_i  (push_valid),
               .in_data_i   (push_data),
               .out_ready_i (rdy_c[1]),
               .out_valid_o (stg_v[0]),
               .out_data_o  (stg_d[0])
            );
         end else begin : g_next
            nand_lu_stage #(.WIDTH(WIDTH)) u_stage (
               .clk         (clk),
               .rst         (rst),
               .in_valid_i  (stg_v[g-1]),
               .in_data_i   (stg_d[g-1]),
               .out_ready_i (rdy_c[g+1]),
               .out_valid_o (stg_v[g]),
               .out_data_o  (stg_d[g])
            );
         end
      end
   endgenerate

   assign out_valid = stg_v[PIPE_STAGES-1];
   assign out_y     = stg_d[PIPE_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fold_state_q <= ST_IDLE;
         acc_q        <= '0;
         rdy_q        <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (in_xfer) begin
            case (fold_state_q)
               ST_IDLE: begin
                  if (in_op == OP_FOLD && !in_last) begin
                     acc_q        <= in_a;
                     fold_state_q <= ST_FOLD;
                  end
               end
               ST_FOLD: begin
                  if (in_last) begin
                     fold_state_q <= ST_IDLE;
                  end else begin
                     acc_q <= acc_nand;
                  end
               end
               default: fold_state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_count = cnt_q;

endmodule

// File: tb/tb_nand_logic_unit.sv
// Directed bench for nand_logic_unit; a second instance with a 4-bit
// counter shares all inputs to exercise counter wrap.
module tb_nand_logic_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic [2:0] in_op = '0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   logic        in_ready, out_valid;
   logic [7:0]  out_y;
   logic [15:0] out_count;
   logic        in_ready4, out_valid4;
   logic [7:0]  out_y4;
   logic [3:0]  out_count4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int accepted;
   logic [7:0] exp_q[$];
   int         pop_cyc_q[$];

   logic [7:0] op_tbl [8];
   logic [7:0] bp_tbl [4];

   nand_logic_unit #(.WIDTH(8), .PIPE_STAGES(2), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_count(out_count)
   );

   nand_logic_unit #(.WIDTH(8), .PIPE_STAGES(2), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
      .out_valid(out_valid4), .out_ready(out_ready), .out_y(out_y4),
      .out_count(out_count4)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h expected none", out_y);
         end else begin
            check("out_y", {24'h0, out_y}, {24'h0, exp_q.pop_front()});
         end
         pop_cyc_q.push_back(cyc);
      end
   end

   // driver: hold a beat until accepted, push expected result if any
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic last,
                       input bit push, input logic [7:0] exp);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_op = op;
      in_last = last;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no in_ready expected in_ready=1");
      end else if (push) begin
         exp_q.push_back(exp);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      op_tbl[0] = 8'h3F; op_tbl[1] = 8'hC0; op_tbl[2] = 8'hFC; op_tbl[3] = 8'h03;
      op_tbl[4] = 8'h3C; op_tbl[5] = 8'hC3; op_tbl[6] = 8'h0F; op_tbl[7] = 8'hF0;
      bp_tbl[0] = 8'hFE; bp_tbl[1] = 8'hFD; bp_tbl[2] = 8'hFC; bp_tbl[3] = 8'hFB;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_count", out_count, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1;
      check("in_ready_after_edge", in_ready, 1);

      // 1: single NAND, latency 2
      send(8'hF0, 8'hCC, 3'b000, 1'b0, 1'b1, 8'h3F);
      @(negedge clk);
      check("lat_cycle1_valid", out_valid, 0);
      @(negedge clk);
      check("lat_cycle2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      check("count_t1", out_count, 1);

      // 2: all opcodes back-to-back
      pop_cyc_q.delete();
      for (int i = 0; i < 8; i++) begin
         send(8'hF0, 8'hCC, 3'(i), 1'b1, 1'b1, op_tbl[i]);
      end
      drain();
      check("t2_results", pop_cyc_q.size(), 8);
      if (pop_cyc_q.size() == 8) begin
         check("t2_no_bubble", pop_cyc_q[7] - pop_cyc_q[0], 7);
      end
      check("count_t2", out_count, 9);

      // 3: fold burst FF,0F,F0 -> 0F
      send(8'hFF, 8'h00, 3'b111, 1'b0, 1'b0, 8'h00);
      send(8'h0F, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00);
      send(8'hF0, 8'h00, 3'b000, 1'b1, 1'b1, 8'h0F);
      drain();
      check("count_t3", out_count, 10);

      // 4: backpressure with 4 NAND beats
      out_ready = 1'b0;
      accepted = 0;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               send(8'(k + 1), 8'hFF, 3'b000, 1'b0, 1'b1, bp_tbl[k]);
               accepted++;
            end
         end
         begin
            repeat (6) @(negedge clk);
            check("bp_accepted", accepted, 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_y_held", out_y, 8'hFE);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("count_t4", out_count, 14);

      // 5: reset mid-fold with a result in flight
      out_ready = 1'b0;
      send(8'h0F, 8'h0F, 3'b000, 1'b0, 1'b1, 8'hF0);
      send(8'h11, 8'h00, 3'b111, 1'b0, 1'b0, 8'h00);
      send(8'h22, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t5_out_valid", out_valid, 0);
      check("t5_out_count", out_count, 0);
      check("t5_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(8'hFF, 8'hFF, 3'b000, 1'b0, 1'b1, 8'h00);
      drain();
      check("count_t5", out_count, 1);

      // 6: 16 more results -> 17 since reset; 4-bit counter wraps to 1
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 8'h00, 3'b000, 1'b0, 1'b1, 8'hFF);
      end
      drain();
      check("count_t6", out_count, 17);
      check("count4_wrap", out_count4, 1);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
